// File: rtl/fwd_operand_select_stage.sv
// N-source operand select stage for the EX forwarding path.
// Registers the chosen operand and flags out-of-range selects.
module fwd_operand_select_stage #(
    parameter int W     = 32,
    parameter int N     = 3,
    parameter int CNT_W = 8,
    localparam int SEL_W = (N > 2) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   data_in,
    input  logic             err_clr,
    output logic             out_valid,
    output logic [W-1:0]     data_out,
    output logic             sel_err,
    output logic [CNT_W-1:0] err_count
);

    logic             valid_q, valid_d;
    logic [W-1:0]     data_q, data_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     mux_val;
    logic             sel_bad;
    logic             log_err;

    // Pick the addressed source; an out-of-range select yields zero
    always_comb begin
        mux_val = '0;
        sel_bad = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (int'(sel) == k) begin
                mux_val = data_in[k*W +: W];
                sel_bad = 1'b0;
            end
        end
    end

    // Only a real capture (not stalled, not flushed) may log an error
    assign log_err = in_valid && sel_bad && !stall && !flush;

    // Next-state: flush beats stall beats capture; error log is separate
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (!stall) begin
            valid_d = in_valid;
            data_d  = in_valid ? mux_val : '0;
        end
        if (log_err) begin
            err_d = 1'b1;
            if (err_clr) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (err_clr) begin
            err_d = 1'b0;
            cnt_d = '0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign data_out  = data_q;
    assign sel_err   = err_q;
    assign err_count = cnt_q;

endmodule

// File: tb/tb_fwd_operand_select_stage.sv
// Bench for fwd_operand_select_stage: directed steps then random traffic.
// Two instances share inputs: default CNT_W=8 and a CNT_W=2 copy.
module tb_fwd_operand_select_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, err_clr;
    logic [1:0]  sel;
    logic [95:0] data_in;
    logic        out_valid, sel_err, s_valid, s_err;
    logic [31:0] data_out, s_data;
    logic [7:0]  err_count;
    logic [1:0]  s_count;

    logic [31:0] src [3];
    int checks = 0;
    int errors = 0;

    // reference state
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_err;
    int          m_c8, m_c2;

    always #5 clk = ~clk;

    fwd_operand_select_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
        .flush(flush), .sel(sel), .data_in(data_in), .err_clr(err_clr),
        .out_valid(out_valid), .data_out(data_out),
        .sel_err(sel_err), .err_count(err_count)
    );

    fwd_operand_select_stage #(.W(32), .N(3), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
        .flush(flush), .sel(sel), .data_in(data_in), .err_clr(err_clr),
        .out_valid(s_valid), .data_out(s_data),
        .sel_err(s_err), .err_count(s_count)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
        src[0] = a;
        src[1] = b;
        src[2] = c;
        data_in = {c, b, a};
    endtask

    task automatic drive(input logic r, input logic v, input logic s,
                         input logic f, input logic [1:0] sl,
                         input logic c);
        rst = r;
        in_valid = v;
        stall = s;
        flush = f;
        sel = sl;
        err_clr = c;
    endtask

    // one clock: update the reference from the applied inputs, then compare
    task automatic tick(input string tag);
        bit logged;
        @(posedge clk);
        logged = 0;
        if (rst) begin
            m_valid = 0;
            m_data = 0;
            m_err = 0;
            m_c8 = 0;
            m_c2 = 0;
        end else begin
            if (flush) begin
                m_valid = 0;
                m_data = 0;
            end else if (!stall) begin
                m_valid = in_valid;
                if (!in_valid) m_data = 0;
                else if (sel < 3) m_data = src[sel];
                else begin
                    m_data = 0;
                    logged = 1;
                end
            end
            if (logged) begin
                m_err = 1;
                m_c8 = err_clr ? 1 : ((m_c8 == 255) ? 255 : m_c8 + 1);
                m_c2 = err_clr ? 1 : ((m_c2 == 3) ? 3 : m_c2 + 1);
            end else if (err_clr) begin
                m_err = 0;
                m_c8 = 0;
                m_c2 = 0;
            end
        end
        #1;
        check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, ".data"}, 64'(data_out), 64'(m_data));
        check({tag, ".err"}, 64'(sel_err), 64'(m_err));
        check({tag, ".cnt"}, 64'(err_count), 64'(m_c8));
        check({tag, ".s_data"}, 64'(s_data), 64'(m_data));
        check({tag, ".s_err"}, 64'(s_err), 64'(m_err));
        check({tag, ".s_cnt"}, 64'(s_count), 64'(m_c2));
    endtask

    initial begin
        m_valid = 0;
        m_data = 0;
        m_err = 0;
        m_c8 = 0;
        m_c2 = 0;
        set_src('1, '1, '1);
        drive(1, 1, 0, 0, 2'd1, 0);
        tick("rst0");
        tick("rst1");
        check("rst.valid_const", 64'(out_valid), 64'(0));
        check("rst.data_const", 64'(data_out), 64'(0));

        set_src(32'h11111111, 32'h22222222, 32'h33333333);
        drive(0, 1, 0, 0, 2'd0, 0);
        tick("selA");
        check("selA_const", 64'(data_out), 64'h11111111);
        sel = 2'd1;
        tick("selB");
        check("selB_const", 64'(data_out), 64'h22222222);
        sel = 2'd2;
        tick("selC");
        check("selC_const", 64'(data_out), 64'h33333333);

        sel = 2'd1;
        tick("pre_stall");
        stall = 1;
        sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            set_src($urandom, $urandom, $urandom);
            tick("stall");
            check("stall_hold", 64'(data_out), 64'h22222222);
        end

        set_src(32'h11111111, 32'h22222222, 32'h33333333);
        drive(0, 1, 1, 1, 2'd3, 0);
        tick("flush_stall");
        check("flush_cnt", 64'(err_count), 64'(0));

        drive(0, 1, 0, 0, 2'd3, 0);
        tick("illegal");
        check("illegal_cnt", 64'(err_count), 64'(1));
        err_clr = 1;
        tick("illegal_clr");
        check("illegal_clr_cnt", 64'(err_count), 64'(1));
        drive(0, 0, 0, 0, 2'd0, 1);
        tick("clr_only");
        check("clr_only_err", 64'(sel_err), 64'(0));

        drive(0, 1, 0, 0, 2'd3, 0);
        for (int i = 0; i < 5; i++) tick("sat");
        check("sat_s_cnt", 64'(s_count), 64'(3));
        sel = 2'd0;
        tick("after_sat");
        check("after_sat_cnt", 64'(s_count), 64'(3));
        check("after_sat_data", 64'(s_data), 64'h11111111);

        for (int i = 0; i < 400; i++) begin
            set_src($urandom, $urandom, $urandom);
            drive(($urandom_range(0, 40) == 0), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
                  2'($urandom_range(0, 3)), $urandom_range(0, 12) == 0);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
